// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states and the digit
// value that saturated results are filled with.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic [3:0] BCD_NINE = 4'd9;
endpackage

// File: rtl/bin_to_bcd_param_if.sv
// Request/result bundle of the binary-to-BCD converter. The master drives the
// request side, the slave (the converter) drives the result side.
interface bin_to_bcd_param_if #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 8
);
  logic                  start;
  logic                  signed_mode;
  logic [IN_WIDTH-1:0]   in;
  logic                  idle;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negative;
  logic                  overflow;

  modport master (output start, signed_mode, in,
                  input  idle, done, bcd, negative, overflow);
  modport slave  (input  start, signed_mode, in,
                  output idle, done, bcd, negative, overflow);
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the double-dabble correction: add 3 when the digit is 5 or
// more, so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/bin_to_bcd_param.sv
// Sequential shift-add-3 binary-to-BCD converter: one operand bit per cycle,
// optional two's-complement input, saturating to all nines on overflow.
module bin_to_bcd_param
  import bcd_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 8
) (
  input logic             clk,
  input logic             reset,
  bin_to_bcd_param_if.slave bus
);
  localparam int CW = $clog2(IN_WIDTH + 1);

  state_e                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [DIGITS-1:0][3:0]    scr_q, scr_adj, scr_nxt;
  logic [IN_WIDTH-1:0]       op_q, op_nxt, mag_d;
  logic                      sign_q, ovf_q, carry, ovf_d;
  logic [4*DIGITS-1:0]       bcd_q;
  logic                      neg_q, ovfo_q, done_q, idle_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.digit_i(scr_q[g]), .digit_o(scr_adj[g]));
  end

  // carry is the bit leaving the top digit; it can only mean overflow
  assign {carry, scr_nxt, op_nxt} = {scr_adj, op_q, 1'b0};
  assign ovf_d = ovf_q | carry;
  // unary minus of the minimum value yields 2^(IN_WIDTH-1) as an unsigned magnitude
  assign mag_d = (bus.signed_mode && bus.in[IN_WIDTH-1]) ? -bus.in : bus.in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovfo_q  <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          op_q    <= mag_d;
          sign_q  <= bus.signed_mode & bus.in[IN_WIDTH-1];
          scr_q   <= '0;
          ovf_q   <= 1'b0;
          cnt_q   <= CW'(IN_WIDTH);
          state_q <= SHIFT;
          idle_q  <= 1'b0;
        end
        SHIFT: begin
          scr_q <= scr_nxt;
          op_q  <= op_nxt;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            neg_q   <= sign_q;
            ovfo_q  <= ovf_d;
            bcd_q   <= ovf_d ? {DIGITS{BCD_NINE}} : scr_nxt;
          end
        end
        DONE: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.idle     = idle_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.negative = neg_q;
  assign bus.overflow = ovfo_q;
endmodule

// File: tb/tb_bin_to_bcd_param.sv
// Bench for bin_to_bcd_param: an 8-digit and a 10-digit instance share the
// same stimulus; results are scoreboarded per instance.
module tb_bin_to_bcd_param;
  typedef struct {
    logic        sm;
    logic [31:0] in;
    logic        neg;
    logic [31:0] bcd8;
    logic        ovf8;
    logic [39:0] bcd10;
    logic        ovf10;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sm = 1'b0;
  logic [31:0] din = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int done8_cnt = 0;
  int done10_cnt = 0;
  logic prev8 = 1'b0, prev10 = 1'b0;
  vec_t q8[$];
  vec_t q10[$];

  bin_to_bcd_param_if #(.IN_WIDTH(32), .DIGITS(8))  if8 ();
  bin_to_bcd_param_if #(.IN_WIDTH(32), .DIGITS(10)) if10 ();

  assign if8.start        = start;
  assign if8.signed_mode  = sm;
  assign if8.in           = din;
  assign if10.start       = start;
  assign if10.signed_mode = sm;
  assign if10.in          = din;

  bin_to_bcd_param #(.IN_WIDTH(32), .DIGITS(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8));
  bin_to_bcd_param #(.IN_WIDTH(32), .DIGITS(10)) u_dut10 (.clk(clk), .reset(reset), .bus(if10));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference by repeated division, independent of the shift-add-3 method.
  function automatic vec_t model(input logic s, input logic [31:0] v);
    vec_t e;
    longint unsigned mag, m;
    e.sm  = s;
    e.in  = v;
    e.neg = s & v[31];
    mag   = e.neg ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
    e.ovf8  = mag > 64'd99999999;
    e.ovf10 = mag > 64'd9999999999;
    m = mag;
    e.bcd8 = '0;
    for (int i = 0; i < 8; i++) begin e.bcd8[4*i +: 4] = 4'(m % 10); m = m / 10; end
    m = mag;
    e.bcd10 = '0;
    for (int i = 0; i < 10; i++) begin e.bcd10[4*i +: 4] = 4'(m % 10); m = m / 10; end
    if (e.ovf8)  e.bcd8  = {8{4'h9}};
    if (e.ovf10) e.bcd10 = {10{4'h9}};
    return e;
  endfunction

  always @(negedge clk) begin
    vec_t e;
    if (if8.done) begin
      done8_cnt++;
      check("done8_width", {63'd0, prev8}, 64'd0);
      if (q8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        check("bcd8", {32'd0, if8.bcd}, {32'd0, e.bcd8});
        check("neg8", {63'd0, if8.negative}, {63'd0, e.neg});
        check("ovf8", {63'd0, if8.overflow}, {63'd0, e.ovf8});
      end
    end
    if (if10.done) begin
      done10_cnt++;
      check("done10_width", {63'd0, prev10}, 64'd0);
      if (q10.size() == 0) check("unexpected_done10", 64'd1, 64'd0);
      else begin
        e = q10.pop_front();
        check("bcd10", {24'd0, if10.bcd}, {24'd0, e.bcd10});
        check("neg10", {63'd0, if10.negative}, {63'd0, e.neg});
        check("ovf10", {63'd0, if10.overflow}, {63'd0, e.ovf10});
      end
    end
    prev8  <= if8.done;
    prev10 <= if10.done;
  end

  // One conversion with latency/idle checks; inputs are scrambled after capture.
  task automatic run_vec(input vec_t v);
    int  cyc;
    bit  got;
    @(negedge clk);
    check("idle_before", {63'd0, if8.idle}, 64'd1);
    start = 1'b1; sm = v.sm; din = v.in;
    @(posedge clk);
    q8.push_back(v);
    q10.push_back(v);
    cyc = 1;
    got = 0;
    @(negedge clk);
    while (!got && cyc <= 60) begin
      if (if8.done) begin
        got = 1;
        check("latency", 64'(cyc), 64'd33);
        check("idle_at_done", {63'd0, if8.idle}, 64'd0);
      end else begin
        if (if8.idle) check("idle_busy", {63'd0, if8.idle}, 64'd0);
        start = (cyc < 30) ? 1'($urandom_range(0, 1)) : 1'b0;
        sm    = 1'($urandom_range(0, 1));
        din   = $urandom;
        @(negedge clk);
        cyc++;
      end
    end
    if (!got) check("done_timeout", 64'd1, 64'd0);
    start = 1'b0;
    @(negedge clk);
    check("done_low_after", {63'd0, if8.done}, 64'd0);
    check("idle_after", {63'd0, if8.idle}, 64'd1);
  endtask

  vec_t tbl[12];

  initial begin
    int d8;
    tbl[0]  = '{1'b0, 32'd42,         1'b0, 32'h00000042, 1'b0, 40'h0000000042, 1'b0};
    tbl[1]  = '{1'b0, 32'd99999999,   1'b0, 32'h99999999, 1'b0, 40'h0099999999, 1'b0};
    tbl[2]  = '{1'b0, 32'd100000000,  1'b0, 32'h99999999, 1'b1, 40'h0100000000, 1'b0};
    tbl[3]  = '{1'b0, 32'h800000EB,   1'b0, 32'h99999999, 1'b1, 40'h2147483883, 1'b0};
    tbl[4]  = '{1'b1, 32'hFFFFFFD6,   1'b1, 32'h00000042, 1'b0, 40'h0000000042, 1'b0};
    tbl[5]  = '{1'b1, 32'h80000000,   1'b1, 32'h99999999, 1'b1, 40'h2147483648, 1'b0};
    tbl[6]  = '{1'b0, 32'd0,          1'b0, 32'h00000000, 1'b0, 40'h0000000000, 1'b0};
    tbl[7]  = '{1'b1, 32'd0,          1'b0, 32'h00000000, 1'b0, 40'h0000000000, 1'b0};
    tbl[8]  = '{1'b0, 32'hFFFFFFFF,   1'b0, 32'h99999999, 1'b1, 40'h4294967295, 1'b0};
    tbl[9]  = '{1'b1, 32'hFFFFFFFF,   1'b1, 32'h00000001, 1'b0, 40'h0000000001, 1'b0};
    tbl[10] = '{1'b1, 32'h7FFFFFFF,   1'b0, 32'h99999999, 1'b1, 40'h2147483647, 1'b0};
    tbl[11] = '{1'b0, 32'd12345678,   1'b0, 32'h12345678, 1'b0, 40'h0012345678, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_idle",  {63'd0, if8.idle}, 64'd1);
    check("rst_done",  {63'd0, if8.done}, 64'd0);
    check("rst_bcd",   {32'd0, if8.bcd}, 64'd0);
    check("rst_neg",   {63'd0, if8.negative}, 64'd0);
    check("rst_ovf",   {63'd0, if8.overflow}, 64'd0);
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);
    for (int i = 0; i < 4; i++) run_vec(model(1'($urandom_range(0, 1)), $urandom));

    // start held high with in changing every cycle: captures land every 34 cycles
    d8 = done8_cnt;
    for (int c = 0; c < 102; c++) begin
      @(negedge clk);
      check("stream_idle", {63'd0, if8.idle}, (c % 34 == 0) ? 64'd1 : 64'd0);
      start = 1'b1;
      sm    = 1'($urandom_range(0, 1));
      din   = $urandom;
      if (c % 34 == 0) begin
        q8.push_back(model(sm, din));
        q10.push_back(model(sm, din));
      end
    end
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && q8.size() != 0; k++) @(negedge clk);
    check("stream_dones", 64'(done8_cnt - d8), 64'd3);
    repeat (2) @(negedge clk);

    // reset in the middle of SHIFT: immediate idle, cleared result, no done
    run_vec(tbl[0]);
    @(negedge clk);
    start = 1'b1; din = 32'd123456; sm = 1'b0;
    @(negedge clk);
    start = 1'b0;
    d8 = done8_cnt;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_idle8",  {63'd0, if8.idle}, 64'd1);
    check("arst_bcd8",   {32'd0, if8.bcd}, 64'd0);
    check("arst_done8",  {63'd0, if8.done}, 64'd0);
    check("arst_neg8",   {63'd0, if8.negative}, 64'd0);
    check("arst_ovf8",   {63'd0, if8.overflow}, 64'd0);
    check("arst_idle10", {63'd0, if10.idle}, 64'd1);
    check("arst_bcd10",  {24'd0, if10.bcd}, 64'd0);
    @(negedge clk);
    start = 1'b1; din = 32'd77;
    @(negedge clk);
    check("start_in_reset", {63'd0, if8.idle}, 64'd1);
    start = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'(done8_cnt - d8), 64'd0);
    check("idle_after_abort", {63'd0, if8.idle}, 64'd1);

    run_vec(tbl[4]);
    check("q8_drained",  64'(q8.size()),  64'd0);
    check("q10_drained", 64'(q10.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_param.md
BIN_TO_BCD_PARAM -- requirements
Module: bin_to_bcd_param

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 32: binary operand width, range 4..64.
REQ-002 The module SHALL have parameter DIGITS, default 8: number of BCD output digits, range 1..20.
REQ-003 The module SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1: reset, asynchronous and active-high.
REQ-005 The module SHALL have port start  input  1: conversion request, sampled only in IDLE.
REQ-006 The module SHALL have port signed_mode  input  1: 1 = treat in as two's complement, sampled with start.
REQ-007 The module SHALL have port in  input  IN_WIDTH: binary operand, sampled with start.
REQ-008 The module SHALL have port idle  output  1: high only in IDLE.
REQ-009 The module SHALL have port done  output  1: one-cycle pulse when the result is valid.
REQ-010 The module SHALL have port bcd  output  4*DIGITS: packed BCD magnitude, digit 0 in bits [3:0].
REQ-011 The module SHALL have port negative  output  1: sign of the last result.
REQ-012 The module SHALL have port overflow  output  1: magnitude exceeded 10^DIGITS-1.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE; IDLE->SHIFT on start, SHIFT->DONE after IN_WIDTH shifts, DONE->IDLE unconditionally.
REQ-014 On the edge that samples start in IDLE, the block SHALL capture the magnitude (two's-complement negation when signed_mode=1 and in[IN_WIDTH-1]=1), the sign, clear the scratch digits and the sticky overflow, and load the shift counter with IN_WIDTH.
REQ-015 Each SHIFT cycle SHALL add 3 to every scratch digit >=5, then shift scratch:operand left by one bit.
REQ-016 Any 1 bit shifted out of the top scratch digit SHALL set the sticky overflow flag.
REQ-017 On the SHIFT->DONE edge, bcd, negative and overflow SHALL be registered together; when overflow=1, bcd SHALL be all digits 9.
REQ-018 done SHALL be high for exactly one cycle (state DONE); the start-sampling edge to the done-high cycle SHALL take IN_WIDTH+1 cycles.
REQ-019 Back-to-back conversions SHALL be accepted at most once every IN_WIDTH+2 cycles.
REQ-020 start in SHIFT or DONE SHALL be ignored; in and signed_mode changes after capture SHALL NOT affect the result.
REQ-021 bcd, negative and overflow SHALL hold their value until the next DONE.
REQ-022 A magnitude of 0 SHALL yield bcd=0, negative=0, overflow=0.
REQ-023 Signed input equal to the minimum value SHALL convert to magnitude 2^(IN_WIDTH-1) without wrap.
REQ-024 A magnitude exactly 10^DIGITS-1 SHALL NOT set overflow.

Reset
REQ-025 When reset is asserted, the state SHALL go to IDLE immediately, regardless of clk.
REQ-026 Reset SHALL set bcd=0, negative=0, overflow=0, done=0 and idle=1.
REQ-027 Reset mid-SHIFT SHALL abort the conversion with no done pulse.
REQ-028 start SHALL be ignored while reset is high.

Structure
REQ-029 Shared package bcd_pkg SHALL hold the FSM state enum and the BCD_NINE digit constant.
REQ-030 The counter width SHALL be $clog2(IN_WIDTH+1), computed locally.
REQ-031 One sub-module, bcd_digit_adj, SHALL hold the combinational per-digit add-3-if->=5 logic and SHALL be instantiated DIGITS times via generate.

Verification
REQ-032 The bench SHALL run on defaults, plus a DIGITS=10 instance for the stimulus needing it; every check SHALL assert done width = 1 cycle and idle timing.
REQ-033 Unsigned, in=42 -> done 33 cycles after the start edge; bcd=0x00000042, negative=0, overflow=0.
REQ-034 Unsigned, in=99999999 -> bcd=0x99999999, overflow=0; then in=100000000 -> bcd=0x99999999, overflow=1.
REQ-035 Unsigned, in=0x800000EB -> overflow=1, bcd=0x99999999; with DIGITS=10 -> bcd=0x2147483883, overflow=0.
REQ-036 signed_mode=1, in=0xFFFFFFD6 -> negative=1, bcd=0x42; then in=0x80000000 with DIGITS=10 -> bcd=0x2147483648, negative=1.
REQ-037 start held high while in changes every cycle -> one done per 34 cycles, each result matching the value captured in IDLE.
REQ-038 reset pulsed 10 cycles into SHIFT -> idle=1 and bcd=0 immediately, with no done pulse.
